// File: rtl/mmio_periph.sv
// Memory-mapped board I/O block: HEX/LED registers, synchronised switches, debounced buttons
// with sticky W1C rising-edge flags. Define MMIO_PERIPH_CYCLE_COUNTER_EN to add a 32-bit cycle counter at 0x14.
module mmio_periph #(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned N_SW            = 16,
  parameter int unsigned N_LED           = 16,
  parameter int unsigned HEX_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [31:0]      addr,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_SW-1:0]  sw_in,
  output logic [N_LED-1:0] led,
  output logic [HEX_W-1:0] hex
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] OFF_HEX   = 3'd0;
  localparam logic [2:0] OFF_LED   = 3'd1;
  localparam logic [2:0] OFF_SW    = 3'd2;
  localparam logic [2:0] OFF_BTN   = 3'd3;
  localparam logic [2:0] OFF_EDGE  = 3'd4;
  localparam logic [2:0] OFF_CYCLE = 3'd5;

  // Bus decode: one 32-byte window, word offset in addr[4:2].
  logic       sel;
  logic [2:0] off;
  logic       wr_hex, wr_led, wr_edge;

  assign sel     = (addr[31:5] == BASE_ADDR[31:5]);
  assign off     = addr[4:2];
  assign wr_hex  = memwrite && sel && (off == OFF_HEX);
  assign wr_led  = memwrite && sel && (off == OFF_LED);
  assign wr_edge = memwrite && sel && (off == OFF_EDGE);

  logic [HEX_W-1:0] hex_q, hex_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [N_SW-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [N_BTN-1:0] btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [N_BTN-1:0] stable_q, stable_d;
  logic [N_BTN-1:0] edge_q, edge_d;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];
  logic [31:0]      cycle_rd;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hex_d    = hex_q;
    led_d    = led_q;
    sw_s1_d  = sw_in;
    sw_s2_d  = sw_s1_q;
    btn_s1_d = btn_in;
    btn_s2_d = btn_s1_q;
    if (wr_hex) hex_d = writedata[HEX_W-1:0];
    if (wr_led) led_d = writedata[N_LED-1:0];
  end

  // Debounce: count while synced differs from stable; accept after DEBOUNCE_CYCLES differing cycles.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (btn_s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) stable_d[i] = btn_s2_q[i];
        else                      cnt_d[i]    = cnt_q[i] + CW'(1);
      end
    end
  end

  // A rising edge of stable beats a simultaneous W1C clear of the same bit.
  always_comb begin
    edge_d = edge_q;
    if (wr_edge) edge_d = edge_q & ~writedata[N_BTN-1:0];
    edge_d = edge_d | (stable_d & ~stable_q);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q    <= '0;
      led_q    <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      stable_q <= '0;
      edge_q   <= '0;
    end else begin
      hex_q    <= hex_d;
      led_q    <= led_d;
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
      stable_q <= stable_d;
      edge_q   <= edge_d;
    end
  end

  // NOTE: the debounce counter array is reset element by element so a pending press is discarded on reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_BTN; i++) begin
      if (reset) cnt_q[i] <= '0;
      else       cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef MMIO_PERIPH_CYCLE_COUNTER_EN
  logic        wr_cycle;
  logic [31:0] cycle_q, cycle_d;

  assign wr_cycle = memwrite && sel && (off == OFF_CYCLE);

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (wr_cycle) cycle_d = writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_d;
  end

  assign cycle_rd = cycle_q;
`else
  assign cycle_rd = '0;
`endif

  // Combinational read mux; reads never alter state, so a read+write returns the pre-write value.
  always_comb begin
    readdata = '0;
    if (memread && sel) begin
      case (off)
        OFF_HEX:   readdata[HEX_W-1:0] = hex_q;
        OFF_LED:   readdata[N_LED-1:0] = led_q;
        OFF_SW:    readdata[N_SW-1:0]  = sw_s2_q;
        OFF_BTN:   readdata[N_BTN-1:0] = stable_q;
        OFF_EDGE:  readdata[N_BTN-1:0] = edge_q;
        OFF_CYCLE: readdata            = cycle_rd;
        default:   readdata            = '0;
      endcase
    end
  end

  assign led = led_q;
  assign hex = hex_q;

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], writedata};

endmodule

// File: tb/tb_mmio_periph.sv
// Scoreboard bench for mmio_periph (DEBOUNCE_CYCLES=4): stimulus pushes expected values, a negedge monitor pops and compares.
module tb_mmio_periph;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite;
  logic [31:0] addr, writedata, readdata;
  logic [4:0]  btn_in;
  logic [15:0] sw_in, led, hex;

  mmio_periph #(
    .BASE_ADDR(BASE), .N_BTN(5), .N_SW(16), .N_LED(16), .HEX_W(16), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite), .addr(addr),
    .writedata(writedata), .readdata(readdata), .btn_in(btn_in), .sw_in(sw_in),
    .led(led), .hex(hex)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {K_RD, K_LED, K_HEX} kind_e;
  typedef struct {
    kind_e       kind;
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic port_req = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", n, act, exp);
    end
  endtask

  // Monitor: the DUT presents an output whenever memread or a port observation is requested.
  always @(negedge clk) begin
    if (memread || port_req) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: output seen with no expected entry");
      end else begin
        cur = exp_q.pop_front();
        case (cur.kind)
          K_LED:   check(cur.name, {16'h0, led}, cur.val);
          K_HEX:   check(cur.name, {16'h0, hex}, cur.val);
          default: check(cur.name, readdata, cur.val);
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; writedata = d; memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string n);
    addr = a; memread = 1'b1;
    exp_q.push_back('{K_RD, n, e});
    tick();
    memread = 1'b0;
  endtask

  task automatic bus_rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e, input string n);
    addr = a; writedata = d; memread = 1'b1; memwrite = 1'b1;
    exp_q.push_back('{K_RD, n, e});
    tick();
    memread = 1'b0; memwrite = 1'b0;
  endtask

  task automatic expect_port(input kind_e k, input logic [31:0] e, input string n);
    port_req = 1'b1;
    exp_q.push_back('{k, n, e});
    tick();
    port_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0;
    addr = '0; writedata = '0; btn_in = '0; sw_in = '0;
    repeat (3) tick();
    reset = 1'b0;

    expect_port(K_LED, 32'h0, "rst_led");
    expect_port(K_HEX, 32'h0, "rst_hex");
    bus_read(BASE + 32'h08, 32'h0, "rst_sw");
    bus_read(BASE + 32'h0C, 32'h0, "rst_btn");
    bus_read(BASE + 32'h10, 32'h0, "rst_edge");

    bus_write(BASE + 32'h00, 32'h0000_BEEF);
    expect_port(K_HEX, 32'h0000_BEEF, "hex_port");
    bus_write(BASE + 32'h04, 32'h0000_A5A5);
    expect_port(K_LED, 32'h0000_A5A5, "led_port");
    bus_read(BASE + 32'h00, 32'h0000_BEEF, "hex_rd");
    bus_read(BASE + 32'h04, 32'h0000_A5A5, "led_rd");
    addr = BASE + 32'h04; memread = 1'b0;
    expect_port(K_RD, 32'h0, "rd_gated");
    bus_write(BASE + 32'h00, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h00, 32'h0000_FFFF, "hex_upper0");

    sw_in = 16'h1234;
    tick();
    bus_read(BASE + 32'h08, 32'h0, "sw_1edge");
    bus_read(BASE + 32'h08, 32'h0000_1234, "sw_2edge");
    bus_write(BASE + 32'h08, 32'h0000_FFFF);
    bus_read(BASE + 32'h08, 32'h0000_1234, "sw_ro");

    btn_in = 5'b00100;
    repeat (5) tick();
    bus_read(BASE + 32'h0C, 32'h0, "btn_5edge");
    bus_read(BASE + 32'h0C, 32'h4, "btn_6edge");
    bus_read(BASE + 32'h10, 32'h4, "edge_set");
    bus_write(BASE + 32'h10, 32'h0);
    bus_read(BASE + 32'h10, 32'h4, "w1c_zero");
    bus_write(BASE + 32'h10, 32'h4);
    bus_read(BASE + 32'h10, 32'h0, "w1c_one");
    bus_read(BASE + 32'h0C, 32'h4, "btn_kept");

    btn_in = 5'b00101;
    repeat (3) tick();
    btn_in = 5'b00100;
    repeat (8) tick();
    bus_read(BASE + 32'h0C, 32'h4, "glitch_btn");
    bus_read(BASE + 32'h10, 32'h0, "glitch_edge");

    btn_in = 5'b00110;
    repeat (5) tick();
    bus_write(BASE + 32'h10, 32'h2);
    bus_read(BASE + 32'h10, 32'h2, "edge_race");
    bus_read(BASE + 32'h0C, 32'h6, "btn1_level");
    bus_write(BASE + 32'h10, 32'h2);
    bus_read(BASE + 32'h10, 32'h0, "edge_clr1");

    bus_read(BASE + 32'h20, 32'h0, "unsel_20");
    bus_read(BASE + 32'h18, 32'h0, "unsel_18");
    bus_read(BASE + 32'h1C, 32'h0, "unsel_1c");
    bus_read(32'h0000_0004, 32'h0, "unsel_low");
    bus_write(BASE + 32'h20, 32'h0000_1111);
    bus_read(BASE + 32'h00, 32'h0000_FFFF, "unsel_wr");
    bus_write(BASE + 32'h18, 32'h0000_1234);
    bus_read(BASE + 32'h18, 32'h0, "wr_18_ignored");

    bus_rw(BASE + 32'h04, 32'h0000_0F0F, 32'h0000_A5A5, "rw_pre");
    bus_read(BASE + 32'h04, 32'h0000_0F0F, "rw_post");
    expect_port(K_LED, 32'h0000_0F0F, "rw_led");

`ifdef MMIO_PERIPH_CYCLE_COUNTER_EN
    bus_write(BASE + 32'h14, 32'hFFFF_FFFE);
    tick();
    bus_read(BASE + 32'h14, 32'hFFFF_FFFF, "cyc_max");
    bus_read(BASE + 32'h14, 32'h0, "cyc_wrap");
    bus_read(BASE + 32'h14, 32'h1, "cyc_inc");
`else
    bus_write(BASE + 32'h14, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h14, 32'h0, "cyc_off");
    tick();
    bus_read(BASE + 32'h14, 32'h0, "cyc_off2");
`endif

    btn_in = 5'b00000;
    repeat (8) tick();
    bus_read(BASE + 32'h0C, 32'h0, "btn_released");
    btn_in = 5'b01000;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    bus_read(BASE + 32'h0C, 32'h0, "mid_rst_5edge");
    bus_read(BASE + 32'h0C, 32'h8, "mid_rst_6edge");
    bus_read(BASE + 32'h10, 32'h8, "mid_rst_edge");
    expect_port(K_LED, 32'h0, "mid_rst_led");
    expect_port(K_HEX, 32'h0, "mid_rst_hex");

    tick();
    check("scoreboard_drain", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
